// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, pixel record, colours and sink state shared by the VGA pixel path.
package vga_pkg;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} sink_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO of pixel_t; pointers carry an extra wrap bit to tell full from empty.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  pixel_t din,
  output pixel_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  pixel_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: clips signed pixel requests to the screen, queues survivors and drains them to the VGA adapter.
// Define VGA_PLOT_SINK_STATS_EN to add saturating plotted/clipped counters.
module vga_plot_sink #(
  parameter int DEPTH = 4,
  parameter int SCR_W = vga_pkg::SCR_W,
  parameter int SCR_H = vga_pkg::SCR_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_x,
  input  logic [7:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_last,
  input  logic        drain_en,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        done
`ifdef VGA_PLOT_SINK_STATS_EN
  ,
  output logic [15:0] plotted_cnt,
  output logic [15:0] clipped_cnt
`endif
);
  import vga_pkg::*;
  sink_state_t state, nxt;
  pixel_t din, head;
  logic full, empty, accept, keep, push, pop;
  int sx, sy;
  assign sx = int'($signed(in_x));
  assign sy = int'($signed(in_y));
  assign keep = sx >= 0 && sx < SCR_W && sy >= 0 && sy < SCR_H;
  assign in_ready = !full;
  assign accept = in_valid && in_ready;
  assign push = accept && keep;
  assign pop = drain_en && !empty;
  assign din = '{x: in_x[7:0], y: in_y[6:0], colour: in_colour};
  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(din), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
    end else begin
      vga_plot <= pop;
      if (pop) {vga_x, vga_y, vga_colour} <= head;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // An empty FIFO in FLUSH implies no pop this cycle, so the last pixel has already left.
  always_comb
    nxt = start ? RUN
        : (state == RUN && accept && in_last) ? FLUSH
        : (state == FLUSH && empty) ? DONE
        : state;
  always_comb done = state == DONE;
`ifdef VGA_PLOT_SINK_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      plotted_cnt <= '0;
      clipped_cnt <= '0;
    end else if (start) begin
      plotted_cnt <= '0;
      clipped_cnt <= '0;
    end else begin
      if (pop && plotted_cnt != 16'hFFFF) plotted_cnt <= plotted_cnt + 16'd1;
      if (accept && !keep && clipped_cnt != 16'hFFFF) clipped_cnt <= clipped_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vga_plot_sink.sv
// tb_vga_plot_sink: queue-based reference model, clip vector table, directed corner sequences and random traffic.
module tb_vga_plot_sink;
  import vga_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst, start, in_valid, in_last, drain_en;
  logic [8:0] in_x;
  logic [7:0] in_y;
  logic [2:0] in_colour;
  logic in_ready, vga_plot, done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
`ifdef VGA_PLOT_SINK_STATS_EN
  logic [15:0] plotted_cnt, clipped_cnt;
`endif
  vga_plot_sink #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_last(in_last), .drain_en(drain_en),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .done(done)
`ifdef VGA_PLOT_SINK_STATS_EN
    , .plotted_cnt(plotted_cnt), .clipped_cnt(clipped_cnt)
`endif
  );
  always #5 clk = ~clk;

  int checks = 0, failures = 0, plots = 0, p0;
  pixel_t q[$];
  pixel_t exp_pix, last_plotted;
  logic exp_plot, exp_done;
  bit job_open, last_seen;
  int exp_pc, exp_cc;

  typedef struct {int x; int y; bit keep;} clip_vec_t;
  clip_vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit on_screen(input logic [8:0] x, input logic [7:0] y);
    int xi, yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    return xi >= 0 && xi < SCR_W && yi >= 0 && yi < SCR_H;
  endfunction

  function automatic void model_reset();
    q.delete();
    exp_plot = 1'b0;
    exp_pix = '0;
    exp_done = 1'b0;
    job_open = 1'b0;
    last_seen = 1'b0;
    exp_pc = 0;
    exp_cc = 0;
  endfunction

  task automatic tick();
    bit acc, pp, emp, kp;
    chk("in_ready", in_ready, 32'(q.size() < DEPTH));
    acc = in_valid && q.size() < DEPTH;
    pp = drain_en && q.size() > 0;
    emp = q.size() == 0;
    kp = on_screen(in_x, in_y);
    @(posedge clk);
    exp_plot = pp;
    if (pp) begin
      exp_pix = q.pop_front();
      if (exp_pc < 65535) exp_pc++;
    end
    if (acc && kp) q.push_back('{x: in_x[7:0], y: in_y[6:0], colour: in_colour});
    if (acc && !kp && exp_cc < 65535) exp_cc++;
    if (start) begin
      job_open = 1; last_seen = 0; exp_done = 0; exp_pc = 0; exp_cc = 0;
    end else if (job_open && !last_seen && acc && in_last) last_seen = 1;
    else if (job_open && last_seen && emp) begin
      job_open = 0; last_seen = 0; exp_done = 1;
    end
    #1;
    chk("vga_plot", vga_plot, exp_plot);
    chk("vga_x", vga_x, exp_pix.x);
    chk("vga_y", vga_y, exp_pix.y);
    chk("vga_colour", vga_colour, exp_pix.colour);
    chk("done", done, exp_done);
`ifdef VGA_PLOT_SINK_STATS_EN
    chk("plotted_cnt", plotted_cnt, exp_pc);
    chk("clipped_cnt", clipped_cnt, exp_cc);
`endif
    if (vga_plot) begin
      plots++;
      last_plotted = {vga_x, vga_y, vga_colour};
    end
  endtask

  task automatic px(input int x, input int y, input logic [2:0] c, input bit last);
    in_valid = 1'b1;
    in_x = x[8:0];
    in_y = y[7:0];
    in_colour = c;
    in_last = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) tick();
    chk("done_wait", done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, 1};       vecs[1] = '{159, 119, 1};  vecs[2] = '{160, 0, 0};
    vecs[3] = '{-1, 0, 0};      vecs[4] = '{0, 120, 0};    vecs[5] = '{0, -1, 0};
    vecs[6] = '{255, 127, 0};   vecs[7] = '{-256, -128, 0}; vecs[8] = '{82, 20, 1};
    vecs[9] = '{159, 0, 1};     vecs[10] = '{0, 119, 1};   vecs[11] = '{-3, 20, 0};
    rst = 1'b1;
    idle();
    drain_en = 1'b0;
    in_x = '0; in_y = '0; in_colour = '0;
    model_reset();
    #12;
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_vga_colour", vga_colour, 0);
    chk("rst_vga_plot", vga_plot, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 1);
    #8 rst = 1'b0;

    // single pixel latency
    drain_en = 1'b1;
    px(0, 0, BLACK, 0);
    tick();
    idle();
    chk("lat_edge_n", vga_plot, 0);
    tick();
    chk("lat_edge_n1", vga_plot, 1);
    tick();
    chk("lat_after", vga_plot, 0);

    // job with two clipped pixels, last one clipped
    do_start();
    p0 = plots;
    px(82, 20, GREEN, 0); tick();
    px(-3, 20, GREEN, 0); tick();
    px(160, 5, GREEN, 1); tick();
    idle();
    wait_done();
    chk("clip_plots", plots - p0, 1);
    chk("clip_x", last_plotted.x, 82);
    chk("clip_y", last_plotted.y, 20);
`ifdef VGA_PLOT_SINK_STATS_EN
    chk("stat_plotted", plotted_cnt, 1);
    chk("stat_clipped", clipped_cnt, 2);
`endif

    // back-pressure with drain stalled
    drain_en = 1'b0;
    p0 = plots;
    for (int i = 0; i < 4; i++) begin
      px(i * 10, i, 3'(i), 0);
      tick();
    end
    chk("ready_full", in_ready, 0);
    px(40, 4, 3'd4, 0);
    tick();
    drain_en = 1'b1;
    tick();
    tick();
    idle();
    repeat (6) tick();
    chk("plots_after_stall", plots - p0, 5);
    chk("last_after_stall", last_plotted.x, 40);

    // full FIFO with concurrent push and pop
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      px(100 + i, 50, GREEN, 0);
      tick();
    end
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      px(110 + i, 60 + i, 3'(i), 0);
      tick();
    end
    idle();
    repeat (8) tick();
    chk("ovl_ready", in_ready, 1);

    // clip boundary table
    foreach (vecs[i]) begin
      do_start();
      px(vecs[i].x, vecs[i].y, GREEN, 1);
      p0 = plots;
      tick();
      idle();
      repeat (3) tick();
      chk("clip_tbl", plots - p0, 32'(vecs[i].keep));
      chk("clip_tbl_done", done, 1);
    end

    // full-screen fill
    do_start();
    drain_en = 1'b1;
    p0 = plots;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        px(x, y, BLACK, x == 159 && y == 119);
        tick();
      end
    idle();
    wait_done();
    chk("fill_plots", plots - p0, 19200);
    repeat (3) tick();
    chk("done_held", done, 1);
    do_start();
    chk("done_cleared", done, 0);

    // reset with entries queued
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      px(7 + i, 9, GREEN, 0);
      tick();
    end
    idle();
    rst = 1'b1;
    #1;
    chk("arst_plot", vga_plot, 0);
    chk("arst_done", done, 0);
    chk("arst_x", vga_x, 0);
    chk("arst_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drain_en = 1'b1;
    p0 = plots;
    repeat (6) tick();
    chk("arst_no_stale", plots - p0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 49) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_x = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 159));
      in_y = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 119));
      in_colour = 3'($urandom_range(0, 7));
      in_last = $urandom_range(0, 15) == 0;
      drain_en = $urandom_range(0, 3) != 0;
      tick();
    end
    idle();
    drain_en = 1'b1;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
